// File: rtl/overlay_fetch_pkg.sv
// Shared types and constants for the overlay fetch path.
package overlay_pkg;

    // RGBA4444 field offsets inside a 16-bit overlay pixel.
    localparam int RGBA_FIELD_W = 4;
    localparam int RGBA_R_LSB   = 0;
    localparam int RGBA_G_LSB   = 4;
    localparam int RGBA_B_LSB   = 8;
    localparam int RGBA_A_LSB   = 12;

    // Supported pixel formats, expressed as pixel width in bits.
    localparam int PIX_FMT_I8       = 8;
    localparam int PIX_FMT_RGBA4444 = 16;

    // Request FSM. WAIT_SYNC holds off fetching until a frame start is seen
    // with the overlay enabled, so the stream always begins frame-aligned.
    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_IDLE      = 2'd1,
        ST_REQ       = 2'd2
    } ovl_req_state_t;

    // Observation bundle for the fetch engine.
    typedef struct packed {
        ovl_req_state_t state;
        logic           discard;
        logic [15:0]    count;
    } ovl_dbg_t;

    // Extract one 4-bit channel from an RGBA4444 pixel.
    function automatic logic [RGBA_FIELD_W-1:0] rgba_field(input logic [15:0] pix, input int lsb);
        return pix[lsb +: RGBA_FIELD_W];
    endfunction

endpackage

// File: rtl/overlay_fetch_if.sv
// SDRAM read channel between the overlay fetcher (master) and memory (slave).
// Handshake: master raises mem_req with mem_addr and holds both stable until
// the slave returns a single-cycle mem_valid pulse carrying mem_data; only one
// request is ever outstanding, and mem_req drops the cycle after mem_valid.
interface overlay_fetch_if #(
    parameter int ADDR_W = 24,
    parameter int WORD_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [WORD_W-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_valid, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_valid, output mem_data);
endinterface

// File: rtl/overlay_fetch_fifo.sv
// Synchronous word FIFO with flush; no read bypass, so a word written on one
// cycle becomes visible at the head on the next.
module ovl_word_fifo #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] ram [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = ram[rd_ptr];

    // Pointer and occupancy tracking; flush wins over any push/pop that cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk_sys) begin
        if (do_push && !flush) ram[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/overlay_fetch.sv
// Overlay pixel streamer: prefetches packed words into a FIFO and unpacks
// them LSB-first, one pixel per qualified active-display pixel cycle.
module overlay_fetch
    import overlay_pkg::*;
#(
    parameter int               WORD_W    = 32,
    parameter int               PIX_W     = PIX_FMT_RGBA4444,
    parameter int               DEPTH     = 8,
    parameter int               ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              ce_pix,
    input  logic              de,
    input  logic              vsync,
    overlay_fetch_if.master   mem,
    output logic [PIX_W-1:0]  pix_out,
    output logic              pix_valid,
    output logic              underrun,
    output ovl_dbg_t          dbg
);
    localparam int PPW   = WORD_W / PIX_W;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ovl_req_state_t    state, state_nxt;
    logic              vsync_q;
    logic              vsync_rise;
    logic              restart;
    logic              in_req;
    logic              resp;
    logic              discard;
    logic [ADDR_W-1:0] addr_q;
    logic              consume;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  pix_idx;
    logic              last_pix;
    logic [WORD_W-1:0] head_word;
    logic [PIX_W-1:0]  head_pix;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    // Disabling the overlay acts as a restart held on every cycle.
    assign vsync_rise = vsync & ~vsync_q;
    assign restart    = vsync_rise | ~enable;
    assign in_req     = (state == ST_REQ);
    assign resp       = in_req & mem.mem_valid;
    assign push       = resp & ~discard & ~restart;
    assign consume    = ce_pix & de & enable;
    assign last_pix   = (pix_idx == IDX_W'(PPW - 1));
    assign pop        = consume & ~fifo_empty & last_pix;

    ovl_word_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (restart),
        .wdata   (mem.mem_data),
        .rdata   (head_word),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Select the current pixel slice from the head word.
    always_comb begin
        head_pix = '0;
        head_pix = head_word[PIX_W*int'(pix_idx) +: PIX_W];
    end

    // Request FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= ST_WAIT_SYNC;
        else          state <= state_nxt;
    end

    // Request FSM next state; a frame start also lets a full FIFO refetch,
    // because the flush on that edge empties it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT_SYNC: if (enable && vsync_rise) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!enable)                       state_nxt = ST_WAIT_SYNC;
                else if (!fifo_full || vsync_rise) state_nxt = ST_REQ;
            end
            ST_REQ: if (mem.mem_valid) state_nxt = enable ? ST_IDLE : ST_WAIT_SYNC;
            default: state_nxt = ST_WAIT_SYNC;
        endcase
    end

    // Request FSM outputs and observation bundle.
    always_comb begin
        mem.mem_req   = in_req;
        mem.mem_addr  = addr_q;
        dbg.state     = state;
        dbg.discard   = discard;
        dbg.count     = 16'(fifo_count);
    end

    // Frame-sync edge detector, sampled every clk_sys independent of ce_pix.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) vsync_q <= 1'b0;
        else          vsync_q <= vsync;
    end

    // Drop-marker for a request that was in flight when the frame restarted.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                 discard <= 1'b0;
        else if (resp)                discard <= 1'b0;
        else if (restart && in_req)   discard <= 1'b1;
    end

    // Fetch address: advances per accepted word; a restart rewinds it, but
    // is deferred to the response when a request is in flight so the
    // address never changes under an asserted mem_req.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= BASE_ADDR;
        end else if (resp) begin
            if (discard || restart) addr_q <= BASE_ADDR;
            else                    addr_q <= addr_q + ADDR_W'(1);
        end else if (restart && !in_req) begin
            addr_q <= BASE_ADDR;
        end
    end

    // Pixel unpack: registered output, zero pixel on an empty FIFO.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pix_out   <= '0;
            pix_valid <= 1'b0;
            pix_idx   <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (!enable) begin
                pix_out <= '0;
                pix_idx <= '0;
            end else begin
                if (consume) begin
                    pix_valid <= 1'b1;
                    if (!fifo_empty) begin
                        pix_out <= head_pix;
                        pix_idx <= last_pix ? '0 : pix_idx + IDX_W'(1);
                    end else begin
                        pix_out <= '0;
                    end
                end
                if (vsync_rise) pix_idx <= '0;
            end
        end
    end

    // Sticky underrun flag, cleared by any restart.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                    underrun <= 1'b0;
        else if (restart)                underrun <= 1'b0;
        else if (consume && fifo_empty)  underrun <= 1'b1;
    end
endmodule

// File: tb/tb_overlay_fetch.sv
// Bench for overlay_fetch: a 16-bit and an 8-bit pixel instance, behavioural
// memory responders, and pixel scoreboards fed by the stimulus code.
module tb_overlay_fetch;
    import overlay_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset_n, enable, enable8, ce_pix, de, vsync;

    overlay_fetch_if #(.ADDR_W(24), .WORD_W(32)) bus16 ();
    overlay_fetch_if #(.ADDR_W(24), .WORD_W(32)) bus8 ();

    logic [15:0] pix16;
    logic        pv16, ur16;
    ovl_dbg_t    dbg16;
    logic [7:0]  pix8;
    logic        pv8, ur8;
    ovl_dbg_t    dbg8;

    overlay_fetch #(.WORD_W(32), .PIX_W(16), .DEPTH(8), .ADDR_W(24)) u_dut16 (
        .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable), .ce_pix(ce_pix),
        .de(de), .vsync(vsync), .mem(bus16), .pix_out(pix16), .pix_valid(pv16),
        .underrun(ur16), .dbg(dbg16));

    overlay_fetch #(.WORD_W(32), .PIX_W(8), .DEPTH(8), .ADDR_W(24)) u_dut8 (
        .clk_sys(clk_sys), .reset_n(reset_n), .enable(enable8), .ce_pix(ce_pix),
        .de(de), .vsync(vsync), .mem(bus8), .pix_out(pix8), .pix_valid(pv8),
        .underrun(ur8), .dbg(dbg8));

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp16_q[$];
    logic [7:0]  exp8_q[$];
    logic [23:0] log16[$];
    logic [23:0] log8[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: 16-bit instance word a = {(2a+2)*1111h, (2a+1)*1111h}.
    function automatic logic [31:0] word16(input logic [23:0] a);
        int ai;
        logic [15:0] lo, hi;
        ai = int'(a);
        lo = 16'((2 * ai + 1) * 32'h1111);
        hi = 16'((2 * ai + 2) * 32'h1111);
        return {hi, lo};
    endfunction

    function automatic logic [15:0] pix16_of(input int w, input int j);
        logic [31:0] wd;
        wd = word16(24'(w));
        return (j == 0) ? wd[15:0] : wd[31:16];
    endfunction

    function automatic logic [31:0] word8(input logic [23:0] a);
        return 32'h44332211 + 32'(a) * 32'h01010101;
    endfunction

    // ---------------- memory responders ----------------
    int          lat16 = 3;
    int          hold_mode = 0;   // 0 none, 1 hold at hold_addr, 2 hold all
    logic [23:0] hold_addr = '0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;
    logic        hold8 = 1'b0;
    int          cnt16 = 0;
    int          cnt8 = 0;

    initial begin
        bus16.mem_valid = 1'b0; bus16.mem_data = '0;
        bus8.mem_valid  = 1'b0; bus8.mem_data  = '0;
        forever begin
            @(negedge clk_sys);
            bus16.mem_valid = 1'b0;
            bus8.mem_valid  = 1'b0;
            if (bus16.mem_req) begin
                cnt16++;
                if (cnt16 >= lat16 && hold_mode != 2 &&
                    !(hold_mode == 1 && bus16.mem_addr == hold_addr)) begin
                    bus16.mem_valid = 1'b1;
                    bus16.mem_data  = ovr_en ? ovr_data : word16(bus16.mem_addr);
                    log16.push_back(bus16.mem_addr);
                    cnt16 = 0;
                end
            end else cnt16 = 0;
            if (bus8.mem_req) begin
                cnt8++;
                if (cnt8 >= 2 && !hold8) begin
                    bus8.mem_valid = 1'b1;
                    bus8.mem_data  = word8(bus8.mem_addr);
                    log8.push_back(bus8.mem_addr);
                    cnt8 = 0;
                end
            end else cnt8 = 0;
        end
    end

    // ---------------- pixel monitors ----------------
    logic [15:0] e16;
    logic [7:0]  e8;
    always @(negedge clk_sys) begin
        if (pv16) begin
            if (exp16_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL pix16_unexpected: got %0h expected none", pix16);
            end else begin
                e16 = exp16_q.pop_front();
                chk("pix16", 64'(pix16), 64'(e16));
            end
        end
        if (pv8) begin
            if (exp8_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL pix8_unexpected: got %0h expected none", pix8);
            end else begin
                e8 = exp8_q.pop_front();
                chk("pix8", 64'(pix8), 64'(e8));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_ce();
        @(negedge clk_sys); ce_pix = 1'b1;
        @(negedge clk_sys); ce_pix = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge clk_sys); vsync = 1'b1;
        @(negedge clk_sys); vsync = 1'b0;
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
        #1;
    endtask

    // Global time limit.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    logic ok;
    int   hits;

    initial begin
        reset_n = 1'b0; enable = 1'b0; enable8 = 1'b0;
        ce_pix = 1'b0; de = 1'b0; vsync = 1'b0;
        cycles(3);

        // Reset values.
        chk("rst_mem_req", 64'(bus16.mem_req), 64'd0);
        chk("rst_mem_addr", 64'(bus16.mem_addr), 64'd0);
        chk("rst_pix_out", 64'(pix16), 64'd0);
        chk("rst_pix_valid", 64'(pv16), 64'd0);
        chk("rst_underrun", 64'(ur16), 64'd0);
        chk("rst_count", 64'(dbg16.count), 64'd0);
        chk("rst_discard", 64'(dbg16.discard), 64'd0);
        chk("rst_state", 64'(dbg16.state), 64'(ST_WAIT_SYNC));
        @(negedge clk_sys); reset_n = 1'b1;
        cycles(2);

        // Fill: 8 requests at 0..7, then requests stop with a full FIFO.
        enable = 1'b1; lat16 = 3;
        pulse_vsync();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin cycles(1); ok = (log16.size() >= 8); end
        chk("fill_timeout", 64'(ok), 64'd1);
        cycles(12);
        chk("fill_req_cnt", 64'(log16.size()), 64'd8);
        for (int i = 0; i < 8 && i < log16.size(); i++) chk("fill_addr", 64'(log16[i]), 64'(i));
        chk("fill_mem_req", 64'(bus16.mem_req), 64'd0);
        chk("fill_count", 64'(dbg16.count), 64'd8);
        chk("fill_next_addr", 64'(bus16.mem_addr), 64'd8);

        // Unpack: LSB-first pixels, refetch at 8 and 9 after two pops.
        de = 1'b1;
        exp16_q.push_back(16'h1111); pulse_ce();
        exp16_q.push_back(16'h2222); pulse_ce();
        exp16_q.push_back(16'h3333); pulse_ce();
        exp16_q.push_back(16'h4444); pulse_ce();
        de = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin cycles(1); ok = (log16.size() >= 10); end
        chk("unpack_refill_timeout", 64'(ok), 64'd1);
        if (log16.size() >= 10) begin
            chk("unpack_addr8", 64'(log16[8]), 64'd8);
            chk("unpack_addr9", 64'(log16[9]), 64'd9);
        end
        cycles(5);
        chk("unpack_count", 64'(dbg16.count), 64'd8);

        // Sustained streaming at PPW=2: words 2..9 with no underrun.
        de = 1'b1;
        for (int w = 2; w < 10; w++) begin
            for (int j = 0; j < 2; j++) begin
                exp16_q.push_back(pix16_of(w, j));
                pulse_ce();
            end
        end
        cycles(2);
        chk("stream_no_underrun", 64'(ur16), 64'd0);

        // Underrun: slow memory after a restart, display keeps pulling.
        lat16 = 20;
        pulse_vsync();
        for (int i = 0; i < 4; i++) begin
            exp16_q.push_back(16'h0000);
            pulse_ce();
        end
        cycles(1);
        chk("underrun_set", 64'(ur16), 64'd1);
        de = 1'b0;
        cycles(30);
        chk("underrun_sticky", 64'(ur16), 64'd1);
        pulse_vsync();
        chk("underrun_cleared", 64'(ur16), 64'd0);

        // Restart while the request for address 5 is in flight.
        lat16 = 3; hold_mode = 1; hold_addr = 24'd5;
        pulse_vsync();
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            cycles(1);
            ok = bus16.mem_req && (bus16.mem_addr == 24'd5) && (dbg16.count == 16'd5);
        end
        chk("mid_req_reach_timeout", 64'(ok), 64'd1);
        pulse_vsync();
        chk("mid_discard_set", 64'(dbg16.discard), 64'd1);
        chk("mid_flushed", 64'(dbg16.count), 64'd0);
        chk("mid_req_held", 64'(bus16.mem_req), 64'd1);
        chk("mid_addr_stable", 64'(bus16.mem_addr), 64'd5);
        ovr_en = 1'b1; ovr_data = 32'hDEADBEEF; hold_mode = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin cycles(1); ok = !bus16.mem_req; end
        chk("mid_resp_timeout", 64'(ok), 64'd1);
        ovr_en = 1'b0;
        chk("mid_dropped_count", 64'(dbg16.count), 64'd0);
        chk("mid_discard_clr", 64'(dbg16.discard), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin cycles(1); ok = bus16.mem_req; end
        chk("mid_rereq_timeout", 64'(ok), 64'd1);
        chk("mid_rereq_addr", 64'(bus16.mem_addr), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin cycles(1); ok = (dbg16.count == 16'd8); end
        chk("mid_refill_timeout", 64'(ok), 64'd1);
        hold_mode = 2;
        de = 1'b1;
        exp16_q.push_back(16'h1111); pulse_ce();
        exp16_q.push_back(16'h2222); pulse_ce();
        de = 1'b0;

        // Asynchronous reset in the middle of a request.
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin cycles(1); ok = bus16.mem_req; end
        chk("arst_req_timeout", 64'(ok), 64'd1);
        @(negedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_mem_req", 64'(bus16.mem_req), 64'd0);
        chk("arst_mem_addr", 64'(bus16.mem_addr), 64'd0);
        chk("arst_pix_out", 64'(pix16), 64'd0);
        chk("arst_pix_valid", 64'(pv16), 64'd0);
        chk("arst_underrun", 64'(ur16), 64'd0);
        chk("arst_count", 64'(dbg16.count), 64'd0);
        chk("arst_state", 64'(dbg16.state), 64'(ST_WAIT_SYNC));
        hold_mode = 0;
        @(negedge clk_sys); reset_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 20; i++) begin cycles(1); if (bus16.mem_req) hits++; end
        chk("arst_no_req_before_vsync", 64'(hits), 64'd0);
        pulse_vsync();
        ok = 1'b0;
        for (int i = 0; i < 5 && !ok; i++) begin cycles(1); ok = bus16.mem_req; end
        chk("arst_req_after_vsync", 64'(ok), 64'd1);
        chk("arst_req_addr", 64'(bus16.mem_addr), 64'd0);

        // 8-bit pixels: one word yields four pixels and one pop.
        enable = 1'b0;
        cycles(30);
        enable8 = 1'b1;
        pulse_vsync();
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin cycles(1); ok = (dbg8.count == 16'd8); end
        chk("p8_fill_timeout", 64'(ok), 64'd1);
        if (log8.size() > 0) chk("p8_first_addr", 64'(log8[0]), 64'd0);
        hold8 = 1'b1;
        de = 1'b1;
        exp8_q.push_back(8'h11); pulse_ce();
        exp8_q.push_back(8'h22); pulse_ce();
        exp8_q.push_back(8'h33); pulse_ce();
        exp8_q.push_back(8'h44); pulse_ce();
        de = 1'b0;
        cycles(2);
        chk("p8_one_pop", 64'(dbg8.count), 64'd7);
        chk("p8_underrun", 64'(ur8), 64'd0);
        hold8 = 1'b0;
        cycles(10);

        chk("exp16_drained", 64'(exp16_q.size()), 64'd0);
        chk("exp8_drained", 64'(exp8_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/overlay_fetch.md
# overlay_fetch

Parametrised overlay pixel streamer. It prefetches packed overlay words from SDRAM into a small FIFO and unpacks them into one pixel per `ce_pix`-qualified active-display cycle. It sits between the SDRAM read channel and the overlay blend stage. It generalises the single-word double buffer to a configurable-depth FIFO, configurable pixel width, in-flight discard on frame restart, and underrun reporting.

## Interface
Parameters:
- `WORD_W`, 32: memory word width; must be a multiple of `PIX_W`.
- `PIX_W`, 16: pixel width; legal values 8 or 16 (RGBA4444 = 16).
- `DEPTH`, 8: FIFO depth in words; power of two, ≥2.
- `ADDR_W`, 24: word address width.
- `BASE_ADDR`, 0: word address of the first pixel word of a frame.

Ports:
- `clk_sys` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: overlay loaded and in use; low = idle, flush.
- `ce_pix` in 1: pixel clock enable.
- `de` in 1: active display (~(hblank|vblank)).
- `vsync` in 1: frame sync; rising edge restarts the frame.
- `mem_req` out 1: read request, held until `mem_valid`.
- `mem_addr` out `ADDR_W`: word address; stable while `mem_req`=1.
- `mem_valid` in 1: one-cycle pulse, `mem_data` valid.
- `mem_data` in `WORD_W`: returned word.
- `pix_out` out `PIX_W`: current overlay pixel.
- `pix_valid` out 1: `pix_out` updated this cycle.
- `underrun` out 1: sticky; a pixel was needed while the FIFO was empty.

## Operation
- PPW = `WORD_W`/`PIX_W`; pixels are unpacked LSB-first (pixel 0 = `mem_data[PIX_W-1:0]`).
- Request FSM has three states:
  - IDLE → REQ when `enable` & (fifo_count + 0) < `DEPTH`.
  - REQ → IDLE on `mem_valid`. The word is pushed unless `discard`=1, and `mem_addr` is incremented after the push, wrapping at 2^`ADDR_W`.
  - At most one request is outstanding at any time.
- `mem_req` is high exactly in REQ. A full FIFO (count=`DEPTH`) blocks new requests.
- Consume happens on `ce_pix & de & enable`:
  - FIFO non-empty: `pix_out` ← slice[pix_idx] of the head word, `pix_valid`=1, pix_idx++. When pix_idx = PPW−1, the word is popped and pix_idx resets to 0.
  - FIFO empty: `pix_out` ← 0, `pix_valid`=1, `underrun` ← 1, and pix_idx is not advanced (the stream slips and realigns at the next frame).
- Frame restart happens on the vsync rising edge, detected on every `clk_sys` and not gated by `ce_pix`:
  - FIFO is flushed, pix_idx=0, `mem_addr`=`BASE_ADDR`, `underrun` ← 0.
  - If in REQ, `discard` ← 1. The request completes, its data is dropped, and `discard` clears on that `mem_valid`.
- `enable`=0 behaves like a continuous restart: FIFO is empty, no new requests, `pix_out`=0. An in-flight request still completes and is discarded.
- Simultaneous push and pop in the same cycle is legal; the count is unchanged.
- A restart coinciding with a push or pop takes priority: the FIFO is empty afterwards.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`BASE_ADDR`, `pix_out`=0, `pix_valid`=0, `underrun`=0, FIFO empty, `discard`=0.
- `mem_req` rises 1 cycle after the vsync edge is registered, or 1 cycle after `mem_valid` if the FIFO is still not full.
- Pixel latency: `pix_out`/`pix_valid` are registered and appear 1 `clk_sys` after the consuming `ce_pix` cycle.
- `pix_valid` is a one-cycle pulse.
- A word pushed on cycle N is poppable on cycle N+1 (no bypass).
- Sustained throughput requirement: memory latency < PPW × `ce_pix` period. The bench checks this at PPW=2.

## Structure
- Package `overlay_pkg` holds:
  - RGBA4444 field offsets (R[3:0], G[7:4], B[11:8], A[15:12]).
  - `PIX_FMT` constants.
  - The request-FSM state enum `ovl_req_state_t`.
- Sub-module `ovl_word_fifo` is a synchronous FIFO parametrised by `WORD_W`/`DEPTH`. It provides push, pop, flush, count, and empty/full, with registered pointers and an async reset.

## Test plan
- Fill: `enable`=1, vsync pulse, memory latency 3, `de`=0 → exactly 8 requests at addresses 0..7, then `mem_req` stays 0 with count=8.
- Unpack: words 0x22221111, 0x44443333, `ce_pix` every 2nd cycle with `de`=1 → `pix_out` = 0x1111, 0x2222, 0x3333, 0x4444, and `mem_addr` advances to 8, 9.
- PIX_W=8: word 0x44332211 → pixels 0x11, 0x22, 0x33, 0x44, one pop.
- Underrun: latency 20 with `de` continuously high → `pix_out`=0, `underrun`=1 held until the next vsync edge, where it clears.
- Restart mid-request: vsync rises while `mem_req`=1 (addr 5); respond with 0xDEADBEEF → the word is dropped, FIFO empty, and the next request is at address 0.
- Async reset: assert `reset_n`=0 mid-REQ → all outputs take their reset values immediately (no clock edge required); after release, no request issues until the next vsync edge with `enable`=1.
